// File: rtl/ndp_pkg.sv
// Shared types and constants for the near-data-processing copy units.
package ndp_pkg;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned TBL_W  = 12;
    localparam int unsigned WORD_W = 32;

    // Word offsets of the descriptor fields inside the offset table
    localparam int unsigned DESC_SRC = 0;
    localparam int unsigned DESC_DST = 1;
    localparam int unsigned DESC_LEN = 2;

    localparam logic [31:0] LOG_BASE_DEFAULT = 32'h0000_8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RD_SRC,
        ST_RD_OLD,
        ST_WR_LOG,
        ST_WR_DST,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ndp_copy_unit_if.sv
// Single-master word memory request port used by each copy unit.
interface ndp_copy_unit_if
    import ndp_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/ndp_copy_unit.sv
// Per-unit copy worker: fetches a (src, dst, len) descriptor from the offset
// table, then copies len words, optionally logging the old destination words.
module ndp_copy_unit
    import ndp_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] LOG_BASE = ADDR_W'(LOG_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clobber_enable,
    input  logic [TBL_W-1:0]  cmd_base,
    output logic              offset_read_enable,
    output logic [TBL_W-1:0]  offset_read_addr,
    input  logic [WORD_W-1:0] offset_read_data,
    ndp_copy_unit_if.master   mem,
    output logic              ndp_status,
    output logic              ndp_done
);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [TBL_W-1:0]  base_q, base_d;
    logic              clob_q, clob_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [WORD_W-1:0] src_word_q, src_word_d;
    logic [WORD_W-1:0] old_word_q, old_word_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              offset_read_enable_d;
    logic [TBL_W-1:0]  offset_read_addr_d;
    logic              ndp_status_d;
    logic              ndp_done_d;
    logic              xfer;

    assign xfer = mem_req_q && mem.mem_ack;

    // State, descriptor latches and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= ST_IDLE;
            cnt_q              <= '0;
            base_q             <= '0;
            clob_q             <= 1'b0;
            idx_q              <= '0;
            len_q              <= '0;
            src_q              <= '0;
            dst_q              <= '0;
            src_word_q         <= '0;
            old_word_q         <= '0;
            mem_req_q          <= 1'b0;
            mem_we_q           <= 1'b0;
            mem_addr_q         <= '0;
            mem_wdata_q        <= '0;
            offset_read_enable <= 1'b0;
            offset_read_addr   <= '0;
            ndp_status         <= 1'b0;
            ndp_done           <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            base_q             <= base_d;
            clob_q             <= clob_d;
            idx_q              <= idx_d;
            len_q              <= len_d;
            src_q              <= src_d;
            dst_q              <= dst_d;
            src_word_q         <= src_word_d;
            old_word_q         <= old_word_d;
            mem_req_q          <= mem_req_d;
            mem_we_q           <= mem_we_d;
            mem_addr_q         <= mem_addr_d;
            mem_wdata_q        <= mem_wdata_d;
            offset_read_enable <= offset_read_enable_d;
            offset_read_addr   <= offset_read_addr_d;
            ndp_status         <= ndp_status_d;
            ndp_done           <= ndp_done_d;
        end
    end

    // Next state and datapath latches
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        clob_d     = clob_q;
        idx_d      = idx_q;
        len_d      = len_q;
        src_d      = src_q;
        dst_d      = dst_q;
        src_word_d = src_word_q;
        old_word_d = old_word_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                    base_d  = cmd_base;
                    clob_d  = clobber_enable;
                    idx_d   = '0;
                end
            end
            ST_FETCH: begin
                cnt_d = cnt_q + 2'd1;
                // Table data lags its strobe by one cycle
                if (cnt_q == 2'(DESC_SRC + 1)) src_d = ADDR_W'(offset_read_data);
                if (cnt_q == 2'(DESC_DST + 1)) dst_d = ADDR_W'(offset_read_data);
                if (cnt_q == 2'(DESC_LEN + 1)) begin
                    len_d   = offset_read_data[LEN_W-1:0];
                    state_d = (len_d != '0) ? ST_RD_SRC : ST_DONE;
                end
            end
            ST_RD_SRC: begin
                if (xfer) begin
                    src_word_d = mem.mem_rdata;
                    state_d    = clob_q ? ST_RD_OLD : ST_WR_DST;
                end
            end
            ST_RD_OLD: begin
                if (xfer) begin
                    old_word_d = mem.mem_rdata;
                    state_d    = ST_WR_LOG;
                end
            end
            ST_WR_LOG: begin
                if (xfer) state_d = ST_WR_DST;
            end
            ST_WR_DST: begin
                if (xfer) begin
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = (idx_d == len_q) ? ST_DONE : ST_RD_SRC;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the upcoming state, registered above
    always_comb begin
        mem_req_d            = 1'b0;
        mem_we_d             = 1'b0;
        mem_addr_d           = '0;
        mem_wdata_d          = '0;
        offset_read_enable_d = 1'b0;
        offset_read_addr_d   = '0;
        ndp_status_d         = (state_d != ST_IDLE);
        ndp_done_d           = (state_d == ST_DONE);
        unique case (state_d)
            ST_FETCH: begin
                if (cnt_d != 2'd3) begin
                    offset_read_enable_d = 1'b1;
                    offset_read_addr_d   = base_d + TBL_W'(cnt_d);
                end
            end
            ST_RD_SRC: begin
                mem_req_d  = 1'b1;
                mem_addr_d = src_d + ADDR_W'(idx_d);
            end
            ST_RD_OLD: begin
                mem_req_d  = 1'b1;
                mem_addr_d = dst_d + ADDR_W'(idx_d);
            end
            ST_WR_LOG: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = LOG_BASE + ADDR_W'(idx_d);
                mem_wdata_d = old_word_d;
            end
            ST_WR_DST: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = dst_d + ADDR_W'(idx_d);
                mem_wdata_d = src_word_d;
            end
            default: ;
        endcase
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ndp_copy_unit.sv
// Directed self-checking bench for ndp_copy_unit with table and memory models.
module tb_ndp_copy_unit;
    import ndp_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        clobber_enable = 1'b0;
    logic [11:0] cmd_base = '0;
    logic        offset_read_enable;
    logic [11:0] offset_read_addr;
    logic [31:0] offset_read_data = '0;
    logic        ndp_status;
    logic        ndp_done;

    ndp_copy_unit_if #(.ADDR_W(ADDR_W)) mif ();

    ndp_copy_unit #(.ADDR_W(ADDR_W), .LOG_BASE(32'h0000_8000)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .clobber_enable     (clobber_enable),
        .cmd_base           (cmd_base),
        .offset_read_enable (offset_read_enable),
        .offset_read_addr   (offset_read_addr),
        .offset_read_data   (offset_read_data),
        .mem                (mif),
        .ndp_status         (ndp_status),
        .ndp_done           (ndp_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int c0 = 0;

    logic [31:0] tbl [4096];
    logic [31:0] mem_arr [65536];

    // Monitor counters, cleared before each job
    int done_cnt, done_rel, status_cnt, oe_cnt, oe_first, oe_last;
    int req_cnt, req_first, xfers, total_wait, stab_err;
    bit rand_mode = 1'b0;

    logic [1:0]  wait_cnt = '0;
    logic [1:0]  wait_tgt = '0;
    logic        hold_v = 1'b0;
    logic [97:0] hold = '0;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) if (offset_read_enable) offset_read_data <= tbl[offset_read_addr];

    assign mif.mem_ack   = (wait_cnt == wait_tgt);
    assign mif.mem_rdata = mem_arr[mif.mem_addr[15:0]];

    // Memory model with optional random wait states and hold-stability tracking
    always @(posedge clk) begin
        if (hold_v && ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata} !== hold))
            stab_err = stab_err + 1;
        if (mif.mem_req && !mif.mem_ack) begin
            hold   <= {mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata};
            hold_v <= 1'b1;
        end else begin
            hold_v <= 1'b0;
        end
        if (mif.mem_req) begin
            if (mif.mem_ack) begin
                if (mif.mem_we) mem_arr[mif.mem_addr[15:0]] <= mif.mem_wdata;
                xfers = xfers + 1;
                wait_cnt <= '0;
                wait_tgt <= rand_mode ? 2'($urandom_range(3, 0)) : 2'd0;
            end else begin
                wait_cnt   <= wait_cnt + 2'd1;
                total_wait = total_wait + 1;
            end
        end else begin
            wait_cnt <= '0;
            if (!rand_mode) wait_tgt <= '0;
        end
    end

    always @(negedge clk) begin
        int rel;
        rel = cyc - c0;
        if (ndp_done) begin done_cnt = done_cnt + 1; done_rel = rel; end
        if (ndp_status) status_cnt = status_cnt + 1;
        if (offset_read_enable) begin
            if (oe_cnt == 0) oe_first = rel;
            oe_last = rel;
            oe_cnt  = oe_cnt + 1;
        end
        if (mif.mem_req) begin
            if (req_cnt == 0) req_first = rel;
            req_cnt = req_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        done_cnt = 0; done_rel = -1; status_cnt = 0; oe_cnt = 0; oe_first = -1; oe_last = -1;
        req_cnt = 0; req_first = -1; xfers = 0; total_wait = 0; stab_err = 0;
    endtask

    // Pulse start for one cycle; called on a falling edge
    task automatic kick(input logic [11:0] base, input logic clob);
        start = 1'b1; clobber_enable = clob; cmd_base = base; c0 = cyc;
        @(negedge clk);
        start = 1'b0; clobber_enable = 1'b0; cmd_base = '0;
    endtask

    task automatic wait_done(input string tag, input int maxcyc);
        int n;
        n = 0;
        while (done_cnt == 0 && n < maxcyc) begin @(negedge clk); n++; end
        chk(tag, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic load_dst();
        for (int i = 0; i < 4; i++) begin
            mem_arr[16'h200 + 16'(i)] = 32'h0000_00A0 + 32'(i);
            mem_arr[16'h8000 + 16'(i)] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) tbl[i] = '0;
        for (int i = 0; i < 65536; i++) mem_arr[i] = '0;
        tbl[12'h010] = 32'h0000_0100; tbl[12'h011] = 32'h0000_0200; tbl[12'h012] = 32'd3;
        tbl[12'h020] = 32'h0000_0100; tbl[12'h021] = 32'h0000_0200; tbl[12'h022] = 32'hFFFF_0000;
        tbl[12'hFFF] = 32'h0000_0300; tbl[12'h000] = 32'h0000_0400; tbl[12'h001] = 32'd4;
        for (int i = 0; i < 4; i++) begin
            mem_arr[16'h100 + 16'(i)] = 32'hC0DE_0100 + 32'(i);
            mem_arr[16'h300 + 16'(i)] = 32'h3300_0000 + 32'(i);
            mem_arr[16'h400 + 16'(i)] = 32'h4400_0000 + 32'(i);
        end
        load_dst();
        clear_mon();

        repeat (3) @(negedge clk);
        chk("rst_req",    32'(mif.mem_req), 32'd0);
        chk("rst_we",     32'(mif.mem_we), 32'd0);
        chk("rst_addr",   32'(mif.mem_addr), 32'd0);
        chk("rst_wdata",  mif.mem_wdata, 32'd0);
        chk("rst_oe",     32'(offset_read_enable), 32'd0);
        chk("rst_oaddr",  32'(offset_read_addr), 32'd0);
        chk("rst_status", 32'(ndp_status), 32'd0);
        chk("rst_done",   32'(ndp_done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Plain copy, zero-wait memory
        clear_mon();
        kick(12'h010, 1'b0);
        wait_done("t1_timeout", 60);
        chk("t1_oe_first", 32'(oe_first), 32'd1);
        chk("t1_oe_last",  32'(oe_last), 32'd3);
        chk("t1_oe_cnt",   32'(oe_cnt), 32'd3);
        chk("t1_req_first", 32'(req_first), 32'd5);
        chk("t1_done_rel", 32'(done_rel), 32'd11);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_xfers",    32'(xfers), 32'd6);
        chk("t1_status",   32'(status_cnt), 32'd11);
        for (int i = 0; i < 3; i++)
            chk("t1_dst", mem_arr[16'h200 + 16'(i)], 32'hC0DE_0100 + 32'(i));
        chk("t1_dst_beyond", mem_arr[16'h203], 32'h0000_00A3);
        chk("t1_log_clean",  mem_arr[16'h8000], 32'd0);

        // Same descriptor with undo logging
        load_dst();
        clear_mon();
        kick(12'h010, 1'b1);
        wait_done("t2_timeout", 80);
        chk("t2_done_rel", 32'(done_rel), 32'd17);
        chk("t2_xfers",    32'(xfers), 32'd12);
        chk("t2_status",   32'(status_cnt), 32'd17);
        for (int i = 0; i < 3; i++) begin
            chk("t2_log", mem_arr[16'h8000 + 16'(i)], 32'h0000_00A0 + 32'(i));
            chk("t2_dst", mem_arr[16'h200 + 16'(i)], 32'hC0DE_0100 + 32'(i));
        end
        chk("t2_log_beyond", mem_arr[16'h8003], 32'd0);

        // Zero length (upper table bits set but ignored)
        clear_mon();
        kick(12'h020, 1'b1);
        wait_done("t3_timeout", 40);
        chk("t3_req_cnt",  32'(req_cnt), 32'd0);
        chk("t3_done_rel", 32'(done_rel), 32'd5);
        chk("t3_status",   32'(status_cnt), 32'd5);
        chk("t3_oe_cnt",   32'(oe_cnt), 32'd3);

        // Random wait states, descriptor wrapping the table index
        clear_mon();
        rand_mode = 1'b1;
        kick(12'hFFF, 1'b1);
        wait_done("t4_timeout", 400);
        rand_mode = 1'b0;
        chk("t4_done_rel", 32'(done_rel), 32'(21 + total_wait));
        chk("t4_stable",   32'(stab_err), 32'd0);
        chk("t4_xfers",    32'(xfers), 32'd16);
        for (int i = 0; i < 4; i++) begin
            chk("t4_log", mem_arr[16'h8000 + 16'(i)], 32'h4400_0000 + 32'(i));
            chk("t4_dst", mem_arr[16'h400 + 16'(i)], 32'h3300_0000 + 32'(i));
        end

        // Extra start pulses while busy, including during DONE
        load_dst();
        clear_mon();
        kick(12'h010, 1'b0);
        @(negedge clk);
        start = 1'b1; clobber_enable = 1'b1; cmd_base = 12'h020;
        @(negedge clk);
        start = 1'b0; clobber_enable = 1'b0; cmd_base = '0;
        repeat (8) @(negedge clk);
        start = 1'b1; cmd_base = 12'h020;
        @(negedge clk);
        start = 1'b0; cmd_base = '0;
        wait_done("t5_timeout", 40);
        repeat (4) @(negedge clk);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_done_rel", 32'(done_rel), 32'd11);
        chk("t5_oe_cnt",   32'(oe_cnt), 32'd3);
        chk("t5_xfers",    32'(xfers), 32'd6);

        // Reset during WR_DST of word 1, then a fresh run
        load_dst();
        clear_mon();
        kick(12'h010, 1'b0);
        repeat (7) @(negedge clk);
        chk("t6_in_wr", 32'({mif.mem_req, mif.mem_we, mif.mem_addr[15:0]}), 32'h3_0201);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_req",    32'(mif.mem_req), 32'd0);
        chk("t6_status", 32'(ndp_status), 32'd0);
        chk("t6_done",   32'(ndp_done), 32'd0);
        chk("t6_oe",     32'(offset_read_enable), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        chk("t6_word0",   mem_arr[16'h200], 32'hC0DE_0100);
        chk("t6_word1",   mem_arr[16'h201], 32'h0000_00A1);
        clear_mon();
        kick(12'h010, 1'b0);
        wait_done("t6b_timeout", 60);
        chk("t6b_done_rel", 32'(done_rel), 32'd11);
        chk("t6b_word2",    mem_arr[16'h202], 32'hC0DE_0102);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ndp_copy_unit.md
# ndp_copy_unit

Per-unit near-data-processing worker that sits directly downstream of `NDPcontroller`. It consumes one bit of `ndp_start` and one bit of `clobber_enable`, and returns the matching bits of `ndp_status` and `ndp_done`. On each start it fetches a three-word descriptor (source, destination, length) from the shared offset table through the controller's offset-read port. It then copies the words over a single-master memory request port, optionally saving the old destination words to an undo log first.

## Interface
Parameters:
- `ADDR_W`, 32: word-address width of the memory port.
- `LOG_BASE`, 32'h0000_8000: word address of the undo-log region.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse from `ndp_start[i]`.
- `clobber_enable`  in  1  log mode; sampled together with `start`.
- `cmd_base`  in  12  offset-table index of the descriptor; sampled with `start`.
- `offset_read_enable`  out  1  offset-table read strobe.
- `offset_read_addr`  out  12  offset-table read index.
- `offset_read_data`  in  32  table data, valid the cycle after the strobe.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  completes the current request.
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high.
- `ndp_status`  out  1  busy; drives `ndp_status[i]`.
- `ndp_done`  out  1  one-cycle completion pulse; drives `ndp_done[i]`.

## Operation
States:
- IDLE: waits for `start`.
- FETCH: 4 cycles, tracked by a 2-bit counter.
- RD_SRC, RD_OLD, WR_LOG, WR_DST: one memory transaction each.
- DONE: emits the completion pulse.

Transitions:
- IDLE -> FETCH when `start`=1. In the same edge, latch `cmd_base` and `clobber_enable`, and clear the word index `idx`.
- FETCH: strobe table index `base`, `base+1`, `base+2` (modulo 4096) on FETCH cycles 0–2.
  - Capture SRC, DST, and LEN = `offset_read_data[15:0]` one cycle after each strobe.
  - After cycle 3: go to RD_SRC if LEN ≠ 0, otherwise go to DONE.
- RD_SRC: read `SRC+idx` and latch the data.
  - Next state is RD_OLD if the clobber latch is set, otherwise WR_DST.
- RD_OLD: read `DST+idx`, latch the old word, go to WR_LOG.
- WR_LOG: write the old word to `LOG_BASE+idx`, go to WR_DST.
- WR_DST: write the source word to `DST+idx`.
  - Increment `idx`.
  - Go to DONE if `idx+1` == LEN, otherwise go to RD_SRC.
- DONE: assert `ndp_done` for 1 cycle, then return to IDLE.

Rules:
- `ndp_status` = 1 in every state except IDLE.
- `start` is ignored while busy; no queuing.
- Address arithmetic is modulo 2^ADDR_W. `idx` and LEN are 16 bits, so the maximum copy is 65535 words.
- A memory transaction completes on the first cycle in which `mem_req` && `mem_ack`.
  - Until then, `mem_req`, `mem_we`, `mem_addr`, and `mem_wdata` are held stable.
  - `mem_req` drops for at least the cycle after completion only when the next state is DONE. Back-to-back requests are otherwise allowed.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- Reset values: all outputs are 0, the state is IDLE, and all latches are 0. Reset asserted mid-operation aborts immediately: `mem_req` drops and no `ndp_done` is produced.
- Let `start` be high in cycle 0.
  - `offset_read_enable` is high in cycles 1–3.
  - The first `mem_req` is in cycle 5.
- With zero-wait ack (`mem_ack` tied 1), `ndp_done` is high in the following cycle:
  - Clobber off: cycle 5 + 2·LEN.
  - Clobber on: cycle 5 + 4·LEN.
  - LEN = 0: cycle 5.
- Each memory wait cycle adds exactly one cycle.
- `ndp_status` rises in cycle 1 and falls in the cycle after `ndp_done`.

## Structure
- Shared package `ndp_pkg`:
  - State enum.
  - Descriptor field offsets (SRC=0, DST=1, LEN=2).
  - LEN width (16).
  - Default `LOG_BASE`.
- No sub-modules. The controller instantiates one `ndp_copy_unit` per unit (8 total) and arbitrates the shared offset-read and memory ports externally.

## Test plan
- Descriptor {SRC=0x100, DST=0x200, LEN=3}, clobber=0, zero-wait memory -> memory 0x200..0x202 equals 0x100..0x102, `ndp_done` in cycle 11, 6 memory transactions.
- Same descriptor with clobber=1 and old DST contents 0xA0..0xA2 -> log 0x8000..0x8002 = 0xA0..0xA2, destination updated, `ndp_done` in cycle 17.
- LEN=0 -> no `mem_req` at all, `ndp_done` in cycle 5, status high in cycles 1–5.
- Random 0–3 wait cycles on `mem_ack` -> request signals stable until ack, data correct, done cycle = nominal + total wait cycles.
- Second `start` pulse while busy -> ignored, exactly one `ndp_done`, no extra table reads.
- `reset` asserted during WR_DST of word 1 -> all outputs 0 next cycle, no `ndp_done`. A fresh start afterwards runs normally.
